sdram_bus_arbiter_n: RTL and testbench
======================================

Name: sdram_bus_arbiter_n

Overview:
Parametrised N-master arbiter for the single SDRAM command/address bus. It hands bus ownership between masters such as the Nios controller, camera writers and future DMA engines. Every ownership change runs a guarded switch sequence: NOP guard, LOAD MODE REGISTER with the incoming master's mode word, then NOP guard. The block adds round-robin selection, a default owner, and optional hold-time preemption. It sits between the per-master SDRAM controllers and the SDRAM pins.

Parameters:
NUM_MASTERS, 2, number of masters (2..8); index 0 = highest priority on ties
ADDR_W, 12, SDRAM address width
BA_W, 2, bank address width
CS_W, 2, chip-select width
DQM_W, 2, data-mask width
NOP_CYCLES, 1, guard NOP cycles before and after the mode load (>=1)
RESET_OWNER, 0, owner granted out of reset
DEFAULT_OWNER, 1, owner the bus returns to when no master requests
MAX_HOLD, 0, cycles an owner may hold against competing requests (0 = no preemption)

Ports:
clk  in  1  system clock
Reset_N  in  1  asynchronous active-low reset
req  in  NUM_MASTERS  per-master ownership request, level
grant  out  NUM_MASTERS  one-hot; master i drives the SDRAM
busy  out  1  switch sequence in progress
owner_idx  out  clog2(NUM_MASTERS)  current or incoming owner index
mode_bits  in  NUM_MASTERS*ADDR_W  per-master mode-register word, packed, master 0 in LSBs
SA_m  in  NUM_MASTERS*ADDR_W  per-master address
BA_m  in  NUM_MASTERS*BA_W  per-master bank
CS_N_m  in  NUM_MASTERS*CS_W  per-master chip selects
CKE_m  in  NUM_MASTERS  per-master clock enable
RAS_N_m / CAS_N_m / WE_N_m  in  NUM_MASTERS each  per-master command strobes
DQM_m  in  NUM_MASTERS*DQM_W  per-master data masks
SA, BA, CS_N, CKE, RAS_N, CAS_N, WE_N, DQM  out  ADDR_W, BA_W, CS_W, 1, 1, 1, 1, DQM_W  SDRAM pins

Behaviour:
- States: OWN, NOP_PRE, LOAD_MODE, NOP_POST. All state is registered on the clk rising edge.
- Reset (async, Reset_N=0): state=OWN, owner=RESET_OWNER, target=RESET_OWNER, grant=one-hot(RESET_OWNER), busy=0, hold counter=0, phase counter=0. The pins pass through master RESET_OWNER.
- Reset asserted mid-switch aborts the sequence immediately. No LOAD is issued after Reset_N deasserts.
- OWN, target selection each cycle:
  - Keep the current owner if req[owner]=1, unless preempted.
  - Preempted means: MAX_HOLD!=0, the hold counter has reached MAX_HOLD, and some other req is high.
  - Otherwise the target is the first requester scanning owner+1, owner+2, ... (mod N), excluding the owner when preempted.
  - If no requester exists, the target is DEFAULT_OWNER.
  - If target==owner, stay in OWN.
  - Otherwise latch target and go to NOP_PRE on the next edge.
- Hold counter: cleared on entry to OWN, increments each OWN cycle, saturates.
- NOP_PRE lasts NOP_CYCLES cycles, then LOAD_MODE for 1 cycle, then NOP_POST for NOP_CYCLES cycles, then OWN with owner=target.
- Switch cost is 2*NOP_CYCLES+1 cycles with no grant (3 at default).
- The target is frozen during the switch. Request changes are ignored until OWN is re-entered; a target that dropped req is still granted, then re-evaluated.
- grant[i]=1 iff state=OWN and owner=i. busy = state!=OWN. owner_idx = target while busy, else owner.
- Arbiter-driven pins in NOP_PRE, LOAD_MODE and NOP_POST:
  - CS_N all 0, CKE 1, BA 0, DQM all 1s.
  - RAS_N=CAS_N=WE_N=1 in the NOP states, 0 in LOAD_MODE.
  - SA = mode_bits[target] during LOAD_MODE, sampled combinationally that cycle; SA = 0 in the NOP states.
- In OWN, all pins are a pure combinational mux of master owner's bus, with no added latency.
- No refresh is issued by this block. The incoming master's controller resumes refresh scheduling on grant.

Test Plan:
- Reset with RESET_OWNER=0: grant=01, busy=0, and SA follows SA_m[0] with no added latency. Drop req[0] with req=00 → NOP, LOAD (SA=mode_bits[1], RAS/CAS/WE=000), NOP, then grant=10 exactly 3 cycles later.
- NUM_MASTERS=4, owner=1 releases, req=1101 → target=2 (round-robin from 2); LOAD drives mode_bits[2]; grant=0100.
- MAX_HOLD=8, owner 0 holds req, req[1] rises at cycle 0 → switch starts once the hold counter reaches 8; grant[1] asserts 3 cycles after the switch begins; MAX_HOLD=0 never preempts.
- NOP_CYCLES=2: busy is high for exactly 5 cycles; command sequence NOP,NOP,LOAD,NOP,NOP with CS_N=0, CKE=1, DQM all 1s throughout.
- Toggle req during the switch (target drops, another master raises) → target is unchanged, owner_idx is stable, and re-evaluation happens in OWN.
- Reset_N pulsed during LOAD_MODE → pins immediately return to master RESET_OWNER's bus; no further LOAD.

Source files
------------

// File: rtl/sdram_bus_arbiter_n.sv
// N-master owner arbiter for the shared SDRAM command/address bus.
// Every ownership change runs a guarded NOP / LOAD MODE / NOP sequence.
module sdram_bus_arbiter_n #(
    parameter int unsigned NUM_MASTERS   = 2,
    parameter int unsigned ADDR_W        = 12,
    parameter int unsigned BA_W          = 2,
    parameter int unsigned CS_W          = 2,
    parameter int unsigned DQM_W         = 2,
    parameter int unsigned NOP_CYCLES    = 1,
    parameter int unsigned RESET_OWNER   = 0,
    parameter int unsigned DEFAULT_OWNER = 1,
    parameter int unsigned MAX_HOLD      = 0
) (
    input  logic                             clk,
    input  logic                             Reset_N,
    input  logic [NUM_MASTERS-1:0]           req,
    output logic [NUM_MASTERS-1:0]           grant,
    output logic                             busy,
    output logic [$clog2(NUM_MASTERS)-1:0]   owner_idx,
    input  logic [NUM_MASTERS*ADDR_W-1:0]    mode_bits,
    input  logic [NUM_MASTERS*ADDR_W-1:0]    SA_m,
    input  logic [NUM_MASTERS*BA_W-1:0]      BA_m,
    input  logic [NUM_MASTERS*CS_W-1:0]      CS_N_m,
    input  logic [NUM_MASTERS-1:0]           CKE_m,
    input  logic [NUM_MASTERS-1:0]           RAS_N_m,
    input  logic [NUM_MASTERS-1:0]           CAS_N_m,
    input  logic [NUM_MASTERS-1:0]           WE_N_m,
    input  logic [NUM_MASTERS*DQM_W-1:0]     DQM_m,
    output logic [ADDR_W-1:0]                SA,
    output logic [BA_W-1:0]                  BA,
    output logic [CS_W-1:0]                  CS_N,
    output logic                             CKE,
    output logic                             RAS_N,
    output logic                             CAS_N,
    output logic                             WE_N,
    output logic [DQM_W-1:0]                 DQM
);
    localparam int unsigned IDX_W  = $clog2(NUM_MASTERS);
    localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int unsigned PH_W   = (NOP_CYCLES > 1) ? $clog2(NOP_CYCLES) : 1;

    typedef enum logic [1:0] {OWN, NOP_PRE, LOAD_MODE, NOP_POST} state_t;

    state_t            state;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  target;
    logic [HOLD_W-1:0] hold_cnt;
    logic [PH_W-1:0]   phase_cnt;

    logic [IDX_W-1:0]  sel_c;
    logic [IDX_W-1:0]  cand;
    logic              preempt;
    logic              found;

    // Target selection: keep owner unless preempted, else round-robin from owner+1.
    always_comb begin
        preempt = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD)) &&
                  (|(req & ~(NUM_MASTERS'(1) << owner)));
        found   = 1'b0;
        sel_c   = IDX_W'(DEFAULT_OWNER);
        cand    = '0;
        if (req[owner] && !preempt) begin
            found = 1'b1;
            sel_c = owner;
        end
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            cand = IDX_W'((32'(owner) + k) % NUM_MASTERS);
            if (!found && req[cand] && !(preempt && cand == owner)) begin
                found = 1'b1;
                sel_c = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state     <= OWN;
            owner     <= IDX_W'(RESET_OWNER);
            target    <= IDX_W'(RESET_OWNER);
            hold_cnt  <= '0;
            phase_cnt <= '0;
            grant     <= NUM_MASTERS'(1) << RESET_OWNER;
            busy      <= 1'b0;
            owner_idx <= IDX_W'(RESET_OWNER);
        end else begin
            unique case (state)
                OWN: begin
                    if (sel_c != owner) begin
                        state     <= NOP_PRE;
                        target    <= sel_c;
                        phase_cnt <= '0;
                        grant     <= '0;
                        busy      <= 1'b1;
                        owner_idx <= sel_c;
                    end else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                NOP_PRE: begin
                    if (phase_cnt == PH_W'(NOP_CYCLES - 1)) begin
                        state     <= LOAD_MODE;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end
                LOAD_MODE: begin
                    state <= NOP_POST;
                end
                NOP_POST: begin
                    if (phase_cnt == PH_W'(NOP_CYCLES - 1)) begin
                        state     <= OWN;
                        owner     <= target;
                        hold_cnt  <= '0;
                        phase_cnt <= '0;
                        grant     <= NUM_MASTERS'(1) << target;
                        busy      <= 1'b0;
                        owner_idx <= target;
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end
                default: state <= OWN;
            endcase
        end
    end

    // Pin mux: owner's bus in OWN, arbiter-driven NOP/LOAD MODE while switching.
    always_comb begin
        SA    = '0;
        BA    = '0;
        CS_N  = '1;
        CKE   = 1'b0;
        RAS_N = 1'b1;
        CAS_N = 1'b1;
        WE_N  = 1'b1;
        DQM   = '1;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (owner == IDX_W'(i)) begin
                SA    = SA_m[i*ADDR_W +: ADDR_W];
                BA    = BA_m[i*BA_W +: BA_W];
                CS_N  = CS_N_m[i*CS_W +: CS_W];
                CKE   = CKE_m[i];
                RAS_N = RAS_N_m[i];
                CAS_N = CAS_N_m[i];
                WE_N  = WE_N_m[i];
                DQM   = DQM_m[i*DQM_W +: DQM_W];
            end
        end
        if (state != OWN) begin
            SA    = '0;
            BA    = '0;
            CS_N  = '0;
            CKE   = 1'b1;
            DQM   = '1;
            RAS_N = (state != LOAD_MODE);
            CAS_N = (state != LOAD_MODE);
            WE_N  = (state != LOAD_MODE);
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                if (state == LOAD_MODE && target == IDX_W'(i)) begin
                    SA = mode_bits[i*ADDR_W +: ADDR_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_bus_arbiter_n.sv
// Directed bench for sdram_bus_arbiter_n: default, 4-master, hold-preempt and 2-NOP instances.
module tb_sdram_bus_arbiter_n;
    logic clk;
    logic rst_n;

    int errors = 0;
    int checks = 0;

    // Shared 2-master bus inputs; instance 0 default, 1 MAX_HOLD=8, 2 NOP_CYCLES=2.
    logic [23:0] mode2 = {12'h231, 12'h120};
    logic [23:0] sa2   = {12'hB22, 12'hA11};
    logic [3:0]  ba2   = {2'b10, 2'b01};
    logic [3:0]  csn2  = {2'b01, 2'b10};
    logic [1:0]  cke2  = 2'b10;
    logic [1:0]  ras2  = 2'b01;
    logic [1:0]  cas2  = 2'b10;
    logic [1:0]  we2   = 2'b01;
    logic [3:0]  dqm2  = {2'b00, 2'b10};

    logic [1:0]  req2    [3];
    logic [1:0]  g2      [3];
    logic        bz2     [3];
    logic        oi2     [3];
    logic [11:0] sa_o2   [3];
    logic [1:0]  ba_o2   [3];
    logic [1:0]  csn_o2  [3];
    logic        cke_o2  [3];
    logic        ras_o2  [3];
    logic        cas_o2  [3];
    logic        we_o2   [3];
    logic [1:0]  dqm_o2  [3];

    logic [47:0] mode4 = {12'h433, 12'h322, 12'h211, 12'h100};
    logic [47:0] sa4   = {12'hD44, 12'hC33, 12'hB22, 12'hA11};
    logic [7:0]  ba4   = 8'hE4;
    logic [7:0]  csn4  = 8'h1B;
    logic [3:0]  cke4  = 4'hF;
    logic [3:0]  ras4  = 4'hF;
    logic [3:0]  cas4  = 4'hF;
    logic [3:0]  we4   = 4'hF;
    logic [7:0]  dqm4  = 8'h00;
    logic [3:0]  req4;
    logic [3:0]  g4;
    logic        bz4;
    logic [1:0]  oi4;
    logic [11:0] sa_o4;
    logic [1:0]  ba_o4;
    logic [1:0]  csn_o4;
    logic        cke_o4;
    logic        ras_o4;
    logic        cas_o4;
    logic        we_o4;
    logic [1:0]  dqm_o4;

    int cnt;
    logic saw;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sdram_bus_arbiter_n u_def (
        .clk(clk), .Reset_N(rst_n), .req(req2[0]), .grant(g2[0]), .busy(bz2[0]),
        .owner_idx(oi2[0]), .mode_bits(mode2), .SA_m(sa2), .BA_m(ba2), .CS_N_m(csn2),
        .CKE_m(cke2), .RAS_N_m(ras2), .CAS_N_m(cas2), .WE_N_m(we2), .DQM_m(dqm2),
        .SA(sa_o2[0]), .BA(ba_o2[0]), .CS_N(csn_o2[0]), .CKE(cke_o2[0]),
        .RAS_N(ras_o2[0]), .CAS_N(cas_o2[0]), .WE_N(we_o2[0]), .DQM(dqm_o2[0])
    );

    sdram_bus_arbiter_n #(.MAX_HOLD(8)) u_hold (
        .clk(clk), .Reset_N(rst_n), .req(req2[1]), .grant(g2[1]), .busy(bz2[1]),
        .owner_idx(oi2[1]), .mode_bits(mode2), .SA_m(sa2), .BA_m(ba2), .CS_N_m(csn2),
        .CKE_m(cke2), .RAS_N_m(ras2), .CAS_N_m(cas2), .WE_N_m(we2), .DQM_m(dqm2),
        .SA(sa_o2[1]), .BA(ba_o2[1]), .CS_N(csn_o2[1]), .CKE(cke_o2[1]),
        .RAS_N(ras_o2[1]), .CAS_N(cas_o2[1]), .WE_N(we_o2[1]), .DQM(dqm_o2[1])
    );

    sdram_bus_arbiter_n #(.NOP_CYCLES(2)) u_nop2 (
        .clk(clk), .Reset_N(rst_n), .req(req2[2]), .grant(g2[2]), .busy(bz2[2]),
        .owner_idx(oi2[2]), .mode_bits(mode2), .SA_m(sa2), .BA_m(ba2), .CS_N_m(csn2),
        .CKE_m(cke2), .RAS_N_m(ras2), .CAS_N_m(cas2), .WE_N_m(we2), .DQM_m(dqm2),
        .SA(sa_o2[2]), .BA(ba_o2[2]), .CS_N(csn_o2[2]), .CKE(cke_o2[2]),
        .RAS_N(ras_o2[2]), .CAS_N(cas_o2[2]), .WE_N(we_o2[2]), .DQM(dqm_o2[2])
    );

    sdram_bus_arbiter_n #(.NUM_MASTERS(4)) u_four (
        .clk(clk), .Reset_N(rst_n), .req(req4), .grant(g4), .busy(bz4),
        .owner_idx(oi4), .mode_bits(mode4), .SA_m(sa4), .BA_m(ba4), .CS_N_m(csn4),
        .CKE_m(cke4), .RAS_N_m(ras4), .CAS_N_m(cas4), .WE_N_m(we4), .DQM_m(dqm4),
        .SA(sa_o4), .BA(ba_o4), .CS_N(csn_o4), .CKE(cke_o4),
        .RAS_N(ras_o4), .CAS_N(cas_o4), .WE_N(we_o4), .DQM(dqm_o4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        req2[0] = 2'b01;
        req2[1] = 2'b01;
        req2[2] = 2'b01;
        req4    = 4'b0001;
        @(negedge clk);

        // Reset state and zero-latency pass-through of master 0
        check("rst_grant", 32'(g2[0]), 32'h1);
        check("rst_busy", 32'(bz2[0]), 32'h0);
        check("rst_oidx", 32'(oi2[0]), 32'h0);
        check("rst_sa", 32'(sa_o2[0]), 32'hA11);
        check("rst_ras", 32'(ras_o2[0]), 32'h1);
        rst_n = 1'b1;
        tick();
        check("own_grant", 32'(g2[0]), 32'h1);
        sa2[11:0] = 12'h5A5;
        #1;
        check("sa_pass", 32'(sa_o2[0]), 32'h5A5);
        sa2[11:0] = 12'hA11;
        #1;

        // Release with no requesters: switch to default owner 1
        req2[0] = 2'b00;
        tick();
        check("pre_busy", 32'(bz2[0]), 32'h1);
        check("pre_grant", 32'(g2[0]), 32'h0);
        check("pre_oidx", 32'(oi2[0]), 32'h1);
        check("pre_cmd", 32'({ras_o2[0], cas_o2[0], we_o2[0]}), 32'h7);
        check("pre_csn", 32'(csn_o2[0]), 32'h0);
        check("pre_cke", 32'(cke_o2[0]), 32'h1);
        check("pre_sa", 32'(sa_o2[0]), 32'h0);
        check("pre_dqm", 32'(dqm_o2[0]), 32'h3);
        check("pre_ba", 32'(ba_o2[0]), 32'h0);
        tick();
        check("ld_sa", 32'(sa_o2[0]), 32'h231);
        check("ld_cmd", 32'({ras_o2[0], cas_o2[0], we_o2[0]}), 32'h0);
        check("ld_busy", 32'(bz2[0]), 32'h1);
        tick();
        check("post_cmd", 32'({ras_o2[0], cas_o2[0], we_o2[0]}), 32'h7);
        check("post_sa", 32'(sa_o2[0]), 32'h0);
        tick();
        check("sw_grant", 32'(g2[0]), 32'h2);
        check("sw_busy", 32'(bz2[0]), 32'h0);
        check("sw_sa", 32'(sa_o2[0]), 32'hB22);
        check("sw_oidx", 32'(oi2[0]), 32'h1);
        tick();
        check("idle_grant", 32'(g2[0]), 32'h2);

        // MAX_HOLD=0: owner 1 keeps the bus against master 0 indefinitely
        req2[0] = 2'b11;
        saw = 1'b0;
        repeat (20) begin
            tick();
            if (bz2[0]) saw = 1'b1;
        end
        check("nohold_busy", 32'(saw), 32'h0);
        check("nohold_grant", 32'(g2[0]), 32'h2);

        // Four masters: round-robin from owner+1, including wrap-around
        req4 = 4'b0010;
        repeat (4) tick();
        check("n4_g1", 32'(g4), 32'h2);
        req4 = 4'b1101;
        tick();
        check("n4_oidx", 32'(oi4), 32'h2);
        check("n4_busy", 32'(bz4), 32'h1);
        tick();
        check("n4_ld_sa", 32'(sa_o4), 32'h322);
        repeat (2) tick();
        check("n4_g2", 32'(g4), 32'h4);
        req4 = 4'b0001;
        repeat (4) tick();
        check("n4_wrap", 32'(g4), 32'h1);

        // Hold-time preemption from a fresh reset with both masters requesting
        rst_n   = 1'b0;
        req2[1] = 2'b11;
        tick();
        rst_n = 1'b1;
        cnt = 0;
        while (!bz2[1] && cnt < 20) begin
            tick();
            cnt++;
        end
        check("hold_start", 32'(cnt), 32'd9);
        repeat (2) tick();
        check("hold_mid", 32'(g2[1]), 32'h0);
        tick();
        check("hold_grant", 32'(g2[1]), 32'h2);
        cnt = 0;
        while (!bz2[1] && cnt < 20) begin
            tick();
            cnt++;
        end
        check("hold_back", 32'(cnt), 32'd9);
        repeat (3) tick();
        check("hold_grant0", 32'(g2[1]), 32'h1);

        // NOP_CYCLES=2: NOP,NOP,LOAD,NOP,NOP with bus-safe pins throughout
        req2[2] = 2'b00;
        for (int t = 0; t < 5; t++) begin
            tick();
            check("n2_busy", 32'(bz2[2]), 32'h1);
            check("n2_cmd", 32'({ras_o2[2], cas_o2[2], we_o2[2]}), (t == 2) ? 32'h0 : 32'h7);
            check("n2_csn", 32'(csn_o2[2]), 32'h0);
            check("n2_cke", 32'(cke_o2[2]), 32'h1);
            check("n2_dqm", 32'(dqm_o2[2]), 32'h3);
        end
        tick();
        check("n2_grant", 32'(g2[2]), 32'h2);
        check("n2_done", 32'(bz2[2]), 32'h0);

        // Request toggling during a switch leaves the target frozen
        req2[0] = 2'b10;
        repeat (4) tick();
        check("tg_start", 32'(g2[0]), 32'h2);
        req2[0] = 2'b01;
        tick();
        check("tg_busy", 32'(bz2[0]), 32'h1);
        check("tg_oidx0", 32'(oi2[0]), 32'h0);
        req2[0] = 2'b10;
        tick();
        check("tg_oidx1", 32'(oi2[0]), 32'h0);
        check("tg_ld_sa", 32'(sa_o2[0]), 32'h120);
        tick();
        check("tg_oidx2", 32'(oi2[0]), 32'h0);
        tick();
        check("tg_grant", 32'(g2[0]), 32'h1);
        tick();
        check("tg_reeval", 32'(bz2[0]), 32'h1);
        check("tg_re_oidx", 32'(oi2[0]), 32'h1);
        repeat (3) tick();
        check("tg_final", 32'(g2[0]), 32'h2);

        // Reset during LOAD_MODE aborts the switch at once
        req2[0] = 2'b01;
        tick();
        tick();
        check("rl_cmd", 32'({ras_o2[0], cas_o2[0], we_o2[0]}), 32'h0);
        rst_n = 1'b0;
        #1;
        check("rl_sa", 32'(sa_o2[0]), 32'hA11);
        check("rl_ras", 32'(ras_o2[0]), 32'h1);
        check("rl_grant", 32'(g2[0]), 32'h1);
        check("rl_busy", 32'(bz2[0]), 32'h0);
        tick();
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            tick();
            if (!ras_o2[0] || bz2[0]) saw = 1'b1;
        end
        check("rl_noload", 32'(saw), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
